retire_trace_unit: RTL
======================

// Module: retire_trace_unit
// PURPOSE
//  Producer side of the processor's per-cycle retire/commit trace. Samples WB-stage retire events
//  (reg write, load, store, halt) plus cache request/hit strobes. Keeps cycle, instruction and
//  cache counters. Packs each event into a record, buffers it in a FIFO and hands it to a
//  consumer (log/ptrace writer or on-chip checker) over a valid/ready interface.
// PARAMETERS
//  DEPTH   8   FIFO entries, power of two, >=4; the last entry is reserved for the halt record
//  CW      32  counter width; all counters wrap modulo 2^CW
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous, active-high reset
//  ev_reg_we    in   1   register file write this cycle
//  ev_wreg      in   3   destination register
//  ev_wdata     in   16  register write data
//  ev_mem_rd    in   1   load retiring
//  ev_mem_wr    in   1   store retiring
//  ev_maddr     in   16  memory address
//  ev_mdata     in   16  store data (ev_mem_wr) or load data (ev_mem_rd)
//  ev_halt      in   1   halt retiring
//  ic_req/ic_hit/dc_req/dc_hit  in  1 each  cache strobes, one count per cycle high
//  tr_valid     out  1   record available
//  tr_ready     in   1   consumer accepts when tr_valid&&tr_ready
//  tr_rec       out  55  {halt,reg_we,mem_rd,mem_wr,wreg[2:0],wdata,maddr,mdata}
//  cycle_cnt/inst_cnt  out  CW  counters
//  ic_req_cnt/ic_hit_cnt/dc_req_cnt/dc_hit_cnt  out  CW  (only with RTU_CACHE_STATS_EN)
//  drop_cnt     out  CW  records dropped on full FIFO
//  overflow     out  1   sticky, set on first drop
//  done         out  1   halt record consumed, FIFO empty
// BEHAVIOUR
//  - Reset: all counters 0, FIFO empty, tr_valid=0, tr_rec=0, overflow=0, done=0, state RUN.
//    Reset mid-drain discards all buffered records.
//  - States: RUN -> DRAIN on an accepted halt; DRAIN -> DONE when FIFO empty; DONE holds until rst.
//  - Event: a cycle in RUN with any of reg_we|mem_rd|mem_wr|halt. Exactly one record per event
//    cycle, all flags combined; a load that writes a register gives one record with reg_we=mem_rd=1.
//  - Push: non-halt event pushed if occupancy < DEPTH-1, else dropped (drop_cnt++, overflow=1).
//    Halt always pushed; the reserved slot guarantees room.
//  - Simultaneous push and pop on a full-minus-one FIFO: both occur, occupancy unchanged.
//  - Latency: record pushed at edge N is on tr_rec with tr_valid=1 after edge N (1 cycle).
//    First-word-fall-through; tr_rec is stable while tr_valid&&!tr_ready.
//  - Counters, RUN only, including the halt cycle:
//    cycle_cnt +1 per cycle; inst_cnt +1 if halt|reg_we|mem_wr.
//    Frozen in DRAIN/DONE. Events in DRAIN/DONE are ignored: no push, no drop count.
//  - done=1 the cycle after the FIFO empties in DRAIN; tr_valid=0 in DONE.
//  - Pointers are log2(DEPTH)+1 bits with wrap bit; full/empty come from pointer compare.
// CONFIGURATION
//  RTU_CACHE_STATS_EN defined: the four cache counters follow the cache strobes, RUN only.
//  Not defined: cache strobe inputs ignored, cache counter outputs tied to 0, no counter flops.
// STRUCTURE
//  Shared package retire_trace_pkg holds:
//    - trace_rec_t packed struct, 55 bits
//    - field widths: REG_W=3, DATA_W=16
//    - rtu_state_e {RUN, DRAIN, DONE}
//  One sub-module trace_fifo (DEPTH x trace_rec_t, sync reset, FWFT, count output).
//  Counters and FSM sit in the top module.
// TESTING
//  1 reset, then reg_we r3=0x1234, ready=1
//    -> next cycle tr_valid=1, rec reg_we=1 wreg=3 wdata=0x1234; inst_cnt=1
//  2 load: reg_we=1 mem_rd=1 maddr=0x0040 mdata=0xBEEF
//    -> single record, both flags set; inst_cnt unchanged by the mem_rd flag alone
//  3 ready=0, DEPTH=8, 9 store events
//    -> 7 buffered, drop_cnt=2, overflow=1; then halt -> accepted into slot 8
//  4 halt with 3 records queued, ready toggling 1/0
//    -> records drain in order, done=1 the cycle after the last pop
//    -> cycle_cnt frozen at its halt-cycle value
//  5 assert rst mid-DRAIN with 2 records queued
//    -> next cycle tr_valid=0, done=0, counters 0, state RUN
//  6 with RTU_CACHE_STATS_EN: ic_req high 5 cycles, ic_hit 3 -> ic_req_cnt=5, ic_hit_cnt=3
//    without the macro -> both counters read 0

Source files
------------

// File: rtl/retire_trace_pkg.sv
// Shared types for the retire trace unit: trace record layout, field widths and FSM states.
package retire_trace_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 16;
    localparam int REC_W  = 4 + REG_W + 3 * DATA_W;

    typedef struct packed {
        logic              halt;
        logic              reg_we;
        logic              mem_rd;
        logic              mem_wr;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] maddr;
        logic [DATA_W-1:0] mdata;
    } trace_rec_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } rtu_state_e;

    // Instructions counted by inst_cnt: a load only counts through its register write.
    function automatic logic retires_inst(input logic halt, input logic reg_we, input logic mem_wr);
        return halt | reg_we | mem_wr;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO of trace records; wrap-bit pointers give full/empty and count.
module trace_fifo
    import retire_trace_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  trace_rec_t i_wdata,
    input  logic       i_pop,
    output trace_rec_t o_rdata,
    output logic       o_empty,
    output logic       o_full,
    output logic [AW:0] o_count
);

    trace_rec_t  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_we;
    logic        w_re;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

    assign w_re = i_pop && !o_empty;
    assign w_we = i_push && (!o_full || w_re);

    // Head is presented combinationally; an empty FIFO shows an all-zero record.
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_re) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/retire_trace_unit.sv
// Retire/commit trace producer: packs WB events into records, buffers them and keeps counters.
// Optional cache statistics counters are built only when RTU_CACHE_STATS_EN is defined.
module retire_trace_unit
    import retire_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ev_reg_we,
    input  logic [REG_W-1:0]  i_ev_wreg,
    input  logic [DATA_W-1:0] i_ev_wdata,
    input  logic              i_ev_mem_rd,
    input  logic              i_ev_mem_wr,
    input  logic [DATA_W-1:0] i_ev_maddr,
    input  logic [DATA_W-1:0] i_ev_mdata,
    input  logic              i_ev_halt,
    input  logic              i_ic_req,
    input  logic              i_ic_hit,
    input  logic              i_dc_req,
    input  logic              i_dc_hit,
    output logic              o_tr_valid,
    input  logic              i_tr_ready,
    output logic [REC_W-1:0]  o_tr_rec,
    output logic [CW-1:0]     o_cycle_cnt,
    output logic [CW-1:0]     o_inst_cnt,
    output logic [CW-1:0]     o_ic_req_cnt,
    output logic [CW-1:0]     o_ic_hit_cnt,
    output logic [CW-1:0]     o_dc_req_cnt,
    output logic [CW-1:0]     o_dc_hit_cnt,
    output logic [CW-1:0]     o_drop_cnt,
    output logic              o_overflow,
    output logic              o_done
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    LAST_FREE = (AW+1)'(DEPTH - 1);
    localparam logic [CW-1:0]  ONE       = CW'(1);

    rtu_state_e    r_state;
    logic [CW-1:0] r_cycle_cnt;
    logic [CW-1:0] r_inst_cnt;
    logic [CW-1:0] r_drop_cnt;
    logic          r_overflow;
    logic          r_done;

    trace_rec_t    w_rec;
    trace_rec_t    w_fifo_rec;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [AW:0]   w_fifo_count;
    logic          w_run;
    logic          w_event;
    logic          w_pop;
    logic          w_room;
    logic          w_push;
    logic          w_drop;
    logic          w_unused;

    assign w_run   = (r_state == RUN);
    assign w_event = w_run && (i_ev_reg_we || i_ev_mem_rd || i_ev_mem_wr || i_ev_halt);

    assign w_rec = '{halt:   i_ev_halt,
                     reg_we: i_ev_reg_we,
                     mem_rd: i_ev_mem_rd,
                     mem_wr: i_ev_mem_wr,
                     wreg:   i_ev_wreg,
                     wdata:  i_ev_wdata,
                     maddr:  i_ev_maddr,
                     mdata:  i_ev_mdata};

    assign o_tr_valid = !w_fifo_empty && (r_state != DONE);
    assign o_tr_rec   = w_fifo_rec;
    assign w_pop      = o_tr_valid && i_tr_ready;

    // The last slot belongs to halt; a same-cycle pop frees one for an ordinary record.
    assign w_room = (w_fifo_count < LAST_FREE) || (w_pop && (w_fifo_count == LAST_FREE));
    assign w_push = w_event && (i_ev_halt || w_room);
    assign w_drop = w_event && !i_ev_halt && !w_room;

    trace_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_rec),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rec),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cycle_cnt <= r_cycle_cnt + ONE;
                    if (retires_inst(i_ev_halt, i_ev_reg_we, i_ev_mem_wr)) begin
                        r_inst_cnt <= r_inst_cnt + ONE;
                    end
                    if (w_drop) begin
                        r_drop_cnt <= r_drop_cnt + ONE;
                        r_overflow <= 1'b1;
                    end
                    if (i_ev_halt) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign o_cycle_cnt = r_cycle_cnt;
    assign o_inst_cnt  = r_inst_cnt;
    assign o_drop_cnt  = r_drop_cnt;
    assign o_overflow  = r_overflow;
    assign o_done      = r_done;

`ifdef RTU_CACHE_STATS_EN
    logic [CW-1:0] r_ic_req_cnt;
    logic [CW-1:0] r_ic_hit_cnt;
    logic [CW-1:0] r_dc_req_cnt;
    logic [CW-1:0] r_dc_hit_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ic_req_cnt <= '0;
            r_ic_hit_cnt <= '0;
            r_dc_req_cnt <= '0;
            r_dc_hit_cnt <= '0;
        end else if (w_run) begin
            if (i_ic_req) r_ic_req_cnt <= r_ic_req_cnt + ONE;
            if (i_ic_hit) r_ic_hit_cnt <= r_ic_hit_cnt + ONE;
            if (i_dc_req) r_dc_req_cnt <= r_dc_req_cnt + ONE;
            if (i_dc_hit) r_dc_hit_cnt <= r_dc_hit_cnt + ONE;
        end
    end

    assign o_ic_req_cnt = r_ic_req_cnt;
    assign o_ic_hit_cnt = r_ic_hit_cnt;
    assign o_dc_req_cnt = r_dc_req_cnt;
    assign o_dc_hit_cnt = r_dc_hit_cnt;
    assign w_unused     = w_fifo_full;
`else
    assign o_ic_req_cnt = '0;
    assign o_ic_hit_cnt = '0;
    assign o_dc_req_cnt = '0;
    assign o_dc_hit_cnt = '0;
    assign w_unused     = ^{w_fifo_full, i_ic_req, i_ic_hit, i_dc_req, i_dc_hit};
`endif

endmodule
